fetch_stage: RTL

Instruction-fetch (IF) pipeline stage: the upstream producer for the decode stage. It holds the program counter and issues requests to the instruction memory over an address/data-handshake interface with one request outstanding. It hands {IR, PC+4} to decode under the IF_over / ID_allow_in valid/ready handshake. It applies taken-branch/jump redirects with MIPS delay-slot semantics and exception flushes (cancel).

---
 rtl/fetch_stage_if.sv | 34 +++
 rtl/fetch_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/response channel plus the
// IF -> ID valid/ready handoff. master = fetch stage, slave = memory/decode side.
interface fetch_stage_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        IF_over;
   logic [63:0] IF_OUT;
   logic        ID_allow_in;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_addr_ok,
      input  inst_data_ok,
      input  inst_rdata,
      output IF_over,
      output IF_OUT,
      input  ID_allow_in
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_addr_ok,
      output inst_data_ok,
      output inst_rdata,
      input  IF_over,
      input  IF_OUT,
      output ID_allow_in
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, one-outstanding instruction-memory requests, a one-entry
// output buffer toward decode, delay-slot redirects and cancel flushes.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_cancel,
   input  logic [31:0]   i_cancel_pc,
   input  logic          i_redirect,
   input  logic [31:0]   i_redirect_pc,
   fetch_stage_if.master fetch_bus
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_FULL = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   // Addresses are kept as word addresses; the byte offset is always zero.
   logic [31:2] r_pc;
   logic [31:2] w_pc_next;
   logic [31:2] r_req_pc;
   logic        r_pend_valid;
   logic        w_pend_valid_next;
   logic [31:2] r_pend_pc;
   logic [31:2] w_pend_pc_next;
   logic [31:0] r_buf_ir;
   logic [31:2] r_buf_pc4;

   logic        w_in_req;
   logic        w_addr_acc;
   logic        w_buf_load;
   logic        w_unused_ok;

   assign w_in_req    = (r_state == S_REQ);
   assign w_addr_acc  = w_in_req & fetch_bus.inst_addr_ok;
   assign w_buf_load  = (r_state == S_WAIT) & fetch_bus.inst_data_ok & ~i_cancel;
   assign w_unused_ok = &{1'b0, i_cancel_pc[1:0], i_redirect_pc[1:0]};

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_REQ;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_REQ: begin
            if (fetch_bus.inst_addr_ok) begin
               w_state_next = i_cancel ? S_DROP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_cancel) begin
               w_state_next = fetch_bus.inst_data_ok ? S_REQ : S_DROP;
            end else if (fetch_bus.inst_data_ok) begin
               w_state_next = S_FULL;
            end
         end
         S_FULL: begin
            if (i_cancel || fetch_bus.ID_allow_in) begin
               w_state_next = S_REQ;
            end
         end
         S_DROP: begin
            // The discarded response retires the request even if another cancel
            // lands in the same cycle; waiting longer would never see data_ok.
            if (fetch_bus.inst_data_ok) begin
               w_state_next = S_REQ;
            end
         end
         default: w_state_next = S_REQ;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      fetch_bus.inst_req  = w_in_req & ~rst;
      fetch_bus.inst_addr = {r_pc, 2'b00};
      fetch_bus.IF_over   = (r_state == S_FULL);
      fetch_bus.IF_OUT    = {r_buf_ir, r_buf_pc4, 2'b00};
   end

   // ---------------- PC and deferred-redirect update ----------------
   always_comb begin
      w_pc_next         = r_pc;
      w_pend_valid_next = r_pend_valid;
      w_pend_pc_next    = r_pend_pc;
      if (i_cancel) begin
         w_pc_next         = i_cancel_pc[31:2];
         w_pend_valid_next = 1'b0;
      end else if (w_in_req) begin
         if (fetch_bus.inst_addr_ok) begin
            w_pend_valid_next = 1'b0;
            if (i_redirect) begin
               w_pc_next = i_redirect_pc[31:2];
            end else if (r_pend_valid) begin
               w_pc_next = r_pend_pc;
            end else begin
               w_pc_next = r_pc + 30'd1;
            end
         end else if (i_redirect) begin
            // Delay slot not yet accepted: its acceptance will load the target.
            w_pend_valid_next = 1'b1;
            w_pend_pc_next    = i_redirect_pc[31:2];
         end
      end else if (i_redirect) begin
         w_pc_next = i_redirect_pc[31:2];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc         <= RESET_PC[31:2];
         r_pend_valid <= 1'b0;
         r_pend_pc    <= '0;
         r_req_pc     <= '0;
      end else begin
         r_pc         <= w_pc_next;
         r_pend_valid <= w_pend_valid_next;
         r_pend_pc    <= w_pend_pc_next;
         if (w_addr_acc) begin
            r_req_pc <= r_pc;
         end
      end
   end

   // ---------------- Output buffer ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf_ir  <= '0;
         r_buf_pc4 <= '0;
      end else if (w_buf_load) begin
         r_buf_ir  <= fetch_bus.inst_rdata;
         r_buf_pc4 <= r_req_pc + 30'd1;
      end
   end

endmodule
